// File: rtl/fcb_multichain_loader_if.sv
// fcb_multichain_loader_if: Wishbone slave bus bundle for the fabric configuration loader.
interface fcb_multichain_loader_if #(parameter int WORD_W = 32);
  logic [2:0]        wb_adr_i;
  logic [WORD_W-1:0] wb_dat_i;
  logic [3:0]        wb_sel_i;
  logic              wb_stb_i;
  logic              wb_cyc_i;
  logic              wb_we_i;
  logic [WORD_W-1:0] wb_dat_o;
  logic              wb_ack_o;
  modport slave (input wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i, output wb_dat_o, wb_ack_o);
  modport master (output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i, input wb_dat_o, wb_ack_o);
endinterface

// File: rtl/fcb_multichain_loader.sv
// fcb_multichain_loader: Wishbone-fed word FIFO shifted into NUM_CHAINS parallel fabric scan chains.
// Define FCB_READBACK_EN to capture chain_tail_i into the RDBK register at every shift.
module fcb_multichain_loader #(
  parameter int NUM_CHAINS = 4,
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 24,
  parameter int DIV_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  fcb_multichain_loader_if.slave wb,
  input  logic [NUM_CHAINS-1:0] chain_tail_i,
  output logic [NUM_CHAINS-1:0] chain_head_o,
  output logic                  prog_clk_o,
  output logic                  prset_o,
  output logic                  greset_o,
  output logic                  op_en_o,
  output logic                  irq_o
);
  localparam int SLICES = WORD_W / NUM_CHAINS;
  localparam int SW = SLICES > 1 ? $clog2(SLICES) : 1;
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, PULSE, DONE} state_t;
  state_t r_state, w_nstate;

  logic              r_ack, r_irq_en, r_done, r_ovf, r_len_err, r_prog_clk, r_prset;
  logic [WORD_W-1:0] r_dat, r_word, w_rdbk, w_bmask, w_rmux;
  logic [LEN_W-1:0]  r_len, r_cnt;
  logic [DIV_W-1:0]  r_div, r_div_act, r_ph;
  logic [SW-1:0]     r_slice;
  logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wp, r_rp;
  logic [AW:0]       r_lvl;
  logic w_acc, w_wr, w_rd, w_busy, w_full, w_empty, w_abort, w_start, w_go;
  logic w_push, w_pop, w_flush, w_ph_end, w_last, w_enter, w_ctrl_wr, w_stat_wr;

  assign w_acc     = wb.wb_stb_i & wb.wb_cyc_i & ~r_ack;
  assign w_wr      = w_acc & wb.wb_we_i;
  assign w_rd      = w_acc & ~wb.wb_we_i;
  assign w_ctrl_wr = w_wr & (wb.wb_adr_i == 3'd0) & wb.wb_sel_i[0];
  assign w_stat_wr = w_wr & (wb.wb_adr_i == 3'd4);
  assign w_busy    = r_state inside {LOAD, SETUP, PULSE};
  assign w_full    = r_lvl == (AW+1)'(FIFO_DEPTH);
  assign w_empty   = r_lvl == '0;
  assign w_abort   = w_ctrl_wr & wb.wb_dat_i[1];
  assign w_start   = w_ctrl_wr & wb.wb_dat_i[0] & ~w_abort & (r_state inside {IDLE, DONE});
  assign w_go      = w_start & (r_len != '0);
  assign w_push    = w_wr & (wb.wb_adr_i == 3'd1) & ~w_full;
  assign w_pop     = (r_state == LOAD) & ~w_empty & ~w_abort;
  assign w_ph_end  = r_ph == r_div_act;
  assign w_last    = ({1'b0, r_cnt} + (LEN_W+1)'(1)) >= {1'b0, r_len};
  assign w_enter   = w_nstate != r_state;
  assign w_flush   = w_abort | ((w_nstate == DONE) & (r_state != DONE));

  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_nstate;

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      IDLE, DONE: if (w_start) w_nstate = w_go ? LOAD : IDLE;
      LOAD:       if (!w_empty) w_nstate = SETUP;
      SETUP:      if (w_ph_end) w_nstate = PULSE;
      PULSE:      if (w_ph_end) w_nstate = w_last ? DONE : (r_slice == SW'(SLICES-1)) ? LOAD : SETUP;
      default:    w_nstate = IDLE;
    endcase
    if (w_abort) w_nstate = IDLE;
  end

  always_comb begin
    for (int i = 0; i < WORD_W; i++) w_bmask[i] = (i < 32) && wb.wb_sel_i[(i / 8) % 4];
  end

  always_comb begin
    case (wb.wb_adr_i)
      3'd0:    w_rmux = WORD_W'({r_irq_en, 2'b00});
      3'd1:    w_rmux = WORD_W'(r_lvl);
      3'd2:    w_rmux = WORD_W'(r_len);
      3'd3:    w_rmux = WORD_W'(r_div);
      3'd4:    w_rmux = WORD_W'({w_empty, w_full, r_len_err, r_ovf, r_done, w_busy});
      3'd5:    w_rmux = WORD_W'(r_cnt);
      3'd6:    w_rmux = w_rdbk;
      default: w_rmux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= wb.wb_stb_i & wb.wb_cyc_i & ~r_ack;
      if (w_rd) r_dat <= w_rmux;
    end

  // Status flags: a hardware set wins over a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_irq_en   <= 1'b0;
      r_len      <= '0;
      r_div      <= '0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_len_err  <= 1'b0;
      r_cnt      <= '0;
      r_prog_clk <= 1'b0;
      r_prset    <= 1'b1;
    end else begin
      if (w_ctrl_wr) r_irq_en <= wb.wb_dat_i[2];
      if (w_wr && wb.wb_adr_i == 3'd2) r_len <= LEN_W'((WORD_W'(r_len) & ~w_bmask) | (wb.wb_dat_i & w_bmask));
      if (w_wr && wb.wb_adr_i == 3'd3) r_div <= DIV_W'((WORD_W'(r_div) & ~w_bmask) | (wb.wb_dat_i & w_bmask));
      r_done     <= (w_abort || w_go) ? 1'b0 : ((w_nstate == DONE) && (r_state != DONE)) ? 1'b1 :
                    (w_stat_wr && wb.wb_dat_i[1]) ? 1'b0 : r_done;
      r_ovf      <= (w_wr && wb.wb_adr_i == 3'd1 && w_full) ? 1'b1 : (w_stat_wr && wb.wb_dat_i[2]) ? 1'b0 : r_ovf;
      r_len_err  <= (w_start && !w_go) ? 1'b1 : (w_stat_wr && wb.wb_dat_i[3]) ? 1'b0 : r_len_err;
      r_cnt      <= w_go ? '0 : (r_state == PULSE && w_ph_end && !(&r_cnt)) ? r_cnt + LEN_W'(1) : r_cnt;
      r_prog_clk <= w_nstate == PULSE;
      r_prset    <= (w_nstate == IDLE) ? 1'b1 : (w_nstate == SETUP) ? 1'b0 : r_prset;
    end

  // The divider is latched at each phase entry so bus writes land on phase boundaries.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_ph      <= '0;
      r_div_act <= '0;
      r_word    <= '0;
      r_slice   <= '0;
    end else begin
      r_ph <= w_enter ? '0 : r_ph + DIV_W'(1);
      if (w_enter) r_div_act <= r_div;
      if (w_pop) begin
        r_word  <= r_mem[r_rp];
        r_slice <= '0;
      end else if (r_state == PULSE && w_ph_end) begin
        r_word  <= r_word >> NUM_CHAINS;
        r_slice <= r_slice + SW'(1);
      end
    end

  always_ff @(posedge clk)
    if (w_push && !w_flush) r_mem[r_wp] <= wb.wb_dat_i;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_lvl <= '0;
    end else if (w_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_lvl <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_lvl <= r_lvl + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end

`ifdef FCB_READBACK_EN
  logic [WORD_W-1:0] r_rdbk;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_rdbk <= '0;
    else if (w_start) r_rdbk <= '0;
    else if (r_state == SETUP && w_nstate == PULSE) r_rdbk <= {r_rdbk[WORD_W-NUM_CHAINS-1:0], chain_tail_i};
  assign w_rdbk = r_rdbk;
`else
  logic w_unused_tail;
  assign w_unused_tail = ^chain_tail_i;
  assign w_rdbk = '0;
`endif

  assign wb.wb_ack_o  = r_ack;
  assign wb.wb_dat_o  = r_dat;
  assign chain_head_o = (r_state inside {SETUP, PULSE}) ? r_word[NUM_CHAINS-1:0] : '0;
  assign prog_clk_o   = r_prog_clk;
  assign prset_o      = r_prset;
  assign greset_o     = r_state != DONE;
  assign op_en_o      = r_state == DONE;
  assign irq_o        = r_irq_en & (r_done | r_ovf | r_len_err);
endmodule

// File: tb/tb_fcb_multichain_loader.sv
// tb_fcb_multichain_loader: scoreboard bench for the multichain loader; bus reads and chain shifts
// are checked by monitors against expectations queued when stimulus is issued.
module tb_fcb_multichain_loader;
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;

  fcb_multichain_loader_if #(.WORD_W(32)) bus();
  logic [3:0] tail = '0, head;
  logic pclk, prset, greset, op_en, irq;

  fcb_multichain_loader dut (
    .clk(clk), .reset(reset), .wb(bus), .chain_tail_i(tail), .chain_head_o(head),
    .prog_clk_o(pclk), .prset_o(prset), .greset_o(greset), .op_en_o(op_en), .irq_o(irq)
  );

  typedef struct {logic [31:0] exp; string nm;} rd_t;
  rd_t rd_q[$];
  logic [3:0] pulse_q[$];
  int n_chk = 0, n_fail = 0;
  int n_pulses = 0, pidx = 0, exp_w = 1, hi_n = 0, lo_n = 0;
  bit chk_w = 1, prev_pc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic xfer(input logic [2:0] a, input logic [31:0] d, input bit we, input logic [3:0] sel);
    @(posedge clk); #1;
    bus.wb_adr_i = a; bus.wb_dat_i = d; bus.wb_sel_i = sel; bus.wb_we_i = we;
    bus.wb_stb_i = 1; bus.wb_cyc_i = 1;
    for (int k = 0; k < 8 && !bus.wb_ack_o; k++) @(negedge clk);
    chk("bus_ack", bus.wb_ack_o, 1);
    #1;
    bus.wb_stb_i = 0; bus.wb_cyc_i = 0; bus.wb_we_i = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] sel = 4'hF);
    xfer(a, d, 1, sel);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
    rd_q.push_back('{exp, nm});
    xfer(a, 32'h0, 0, 4'hF);
  endtask

  // Expected chain heads for a word: the first n nibbles, least significant first.
  task automatic push_word(input logic [31:0] w, input int n);
    wr(3'd1, w);
    for (int k = 0; k < n; k++) pulse_q.push_back(4'((w >> (4 * k)) & 32'hF));
  endtask

  task automatic start(input logic [31:0] extra = 0);
    pidx = 0;
    wr(3'd0, 32'h1 | extra);
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 3000 && !op_en; i++) @(negedge clk);
    chk({nm, "_op_en"}, op_en, 1);
    chk({nm, "_pulses_left"}, pulse_q.size(), 0);
  endtask

  always @(negedge clk)
    if (reset && bus.wb_ack_o && !bus.wb_we_i) begin
      rd_t r;
      if (rd_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_read_ack: got %h expected no read", bus.wb_dat_o);
      end else begin
        r = rd_q.pop_front();
        chk(r.nm, bus.wb_dat_o, r.exp);
      end
    end

  // Pulse monitor: checks head value at each rising prog_clk and phase widths in clk cycles.
  always @(negedge clk)
    if (!reset) begin
      prev_pc = 0; hi_n = 0; lo_n = 0;
    end else begin
      if (pclk && !prev_pc) begin
        n_pulses++;
        if (chk_w && pidx % 8 != 0) chk("low_width", lo_n, exp_w);
        if (pulse_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_pulse: got head %h expected no pulse", head);
        end else chk("chain_head", head, pulse_q.pop_front());
        tail = head;
        pidx++;
        hi_n = 1;
      end else if (pclk) hi_n++;
      else if (prev_pc) begin
        if (chk_w) chk("high_width", hi_n, exp_w);
        lo_n = 1;
      end else lo_n++;
      prev_pc = pclk;
    end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int nb, len, nw, n;
    logic [31:0] w;
    bus.wb_adr_i = 0; bus.wb_dat_i = 0; bus.wb_sel_i = 0;
    bus.wb_stb_i = 0; bus.wb_cyc_i = 0; bus.wb_we_i = 0;
    #12;
    chk("rst_ack", bus.wb_ack_o, 0);
    chk("rst_dat", bus.wb_dat_o, 0);
    chk("rst_head", head, 0);
    chk("rst_pclk", pclk, 0);
    chk("rst_prset", prset, 1);
    chk("rst_greset", greset, 1);
    chk("rst_op_en", op_en, 0);
    chk("rst_irq", irq, 0);
    @(negedge clk); reset = 1;
    rd(3'd4, 32'h20, "status_after_reset");

    // Two known words, DIV=0, LEN=16
    exp_w = 1;
    wr(3'd3, 0);
    wr(3'd2, 16);
    push_word(32'h87654321, 8);
    push_word(32'h0FEDCBA9, 8);
    rd(3'd1, 2, "fifo_level_preload");
    start();
    wait_done("known");
    chk("known_greset", greset, 0);
    chk("known_prset", prset, 0);
    rd(3'd4, 32'h22, "known_status");
    rd(3'd5, 16, "known_cnt");
    rd(3'd1, 0, "known_level");
`ifdef FCB_READBACK_EN
    rd(3'd6, 32'h89ABCDEF, "readback");
`else
    rd(3'd6, 32'h0, "readback");
`endif

    // Randomized runs restarted from DONE, with one surplus word that DONE must flush
    for (int r = 0; r < 4; r++) begin
      exp_w = $urandom_range(1, 3);
      wr(3'd3, exp_w - 1);
      len = $urandom_range(1, 20);
      wr(3'd2, len);
      nw = (len + 7) / 8;
      for (int i = 0; i <= nw; i++) begin
        n = len - 8 * i;
        n = n < 0 ? 0 : n > 8 ? 8 : n;
        w = $urandom;
        push_word(w, n);
      end
      start();
      wait_done("rand");
      rd(3'd4, 32'h22, "rand_status");
      rd(3'd5, len, "rand_cnt");
      rd(3'd1, 0, "rand_level");
    end

    // DIV=3, one word, LEN=16: stall in LOAD after 8 shifts, resume on second push
    exp_w = 4;
    wr(3'd3, 3);
    wr(3'd2, 16);
    push_word(32'hA5C3_1E7F, 8);
    nb = n_pulses;
    start();
    for (int i = 0; i < 400 && n_pulses < nb + 8; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    chk("stall_pulses", n_pulses - nb, 8);
    chk("stall_pclk", pclk, 0);
    rd(3'd4, 32'h21, "stall_status");
    push_word(32'h1357_9BDF, 8);
    wait_done("resume");
    rd(3'd4, 32'h22, "resume_status");
    rd(3'd5, 16, "resume_cnt");

    // Overflow and interrupt
    wr(3'd4, 32'hE);
    wr(3'd0, 32'h4);
    chk("irq_clear", irq, 0);
    for (int i = 0; i < 9; i++) push_word($urandom, 0);
    rd(3'd1, 8, "ovf_level");
    rd(3'd4, 32'h14, "ovf_status");
    chk("ovf_irq", irq, 1);
    wr(3'd4, 32'h4);
    chk("ovf_irq_cleared", irq, 0);
    rd(3'd4, 32'h10, "ovf_cleared_status");

    // ABORT from DONE, byte-enable masking, LEN=0 error
    wr(3'd0, 32'h6);
    chk("abort_greset", greset, 1);
    chk("abort_op_en", op_en, 0);
    chk("abort_prset", prset, 1);
    rd(3'd1, 0, "abort_level");
    rd(3'd4, 32'h20, "abort_status");
    wr(3'd2, 32'h00AB_CD00);
    wr(3'd2, 32'hFFFF_FF12, 4'b0001);
    rd(3'd2, 32'h00AB_CD12, "len_byte_sel");
    wr(3'd2, 0);
    nb = n_pulses;
    start(32'h4);
    rd(3'd4, 32'h28, "len_err_status");
    chk("len_err_irq", irq, 1);
    repeat (10) @(negedge clk);
    chk("len_err_no_pulse", n_pulses - nb, 0);
    wr(3'd4, 32'h8);
    chk("len_err_irq_cleared", irq, 0);
    rd(3'd0, 32'h4, "ctrl_irq_en");

    // ABORT mid-shift
    exp_w = 3;
    wr(3'd3, 2);
    wr(3'd2, 16);
    push_word(32'h2468_ACE0, 8);
    push_word(32'hFDB9_7531, 8);
    nb = n_pulses;
    start();
    for (int i = 0; i < 200 && n_pulses < nb + 3; i++) @(negedge clk);
    chk("pre_abort_pulses", n_pulses - nb >= 3, 1);
    chk_w = 0;
    wr(3'd0, 32'h2);
    pulse_q.delete();
    chk("midabort_pclk", pclk, 0);
    chk("midabort_prset", prset, 1);
    chk("midabort_head", head, 0);
    chk("midabort_greset", greset, 1);
    chk("midabort_op_en", op_en, 0);
    rd(3'd1, 0, "midabort_level");
    rd(3'd4, 32'h20, "midabort_status");

    // Asynchronous reset while prog_clk is high
    chk_w = 1;
    exp_w = 8;
    wr(3'd3, 7);
    wr(3'd2, 8);
    push_word(32'h5A5A_3C3C, 8);
    start();
    for (int i = 0; i < 200 && !pclk; i++) @(negedge clk);
    chk("pre_reset_pclk", pclk, 1);
    #2 reset = 0;
    #1;
    chk("areset_pclk", pclk, 0);
    chk("areset_prset", prset, 1);
    chk("areset_greset", greset, 1);
    chk("areset_op_en", op_en, 0);
    chk("areset_head", head, 0);
    chk("areset_irq", irq, 0);
    chk("areset_ack", bus.wb_ack_o, 0);
    pulse_q.delete();
    repeat (2) @(negedge clk);
    reset = 1;
    rd(3'd4, 32'h20, "post_reset_status");
    rd(3'd5, 0, "post_reset_cnt");
    rd(3'd2, 0, "post_reset_len");
    rd(3'd3, 0, "post_reset_div");
    rd(3'd7, 0, "reg7");

    chk("reads_outstanding", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
